// File: rtl/mem_arbiter_if.sv
// Pipeline-to-SRAM port bundle for the instruction/data arbiter.
// master = pipeline + SRAM side, slave = arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              ice;
  logic [ADDR_W-1:0] iaddr;
  logic              dce;
  logic [ADDR_W-1:0] daddr;
  logic [3:0]        dwe;
  logic [31:0]       din;
  logic              flush;
  logic [31:0]       sram_rdata;

  logic              sram_en;
  logic [3:0]        sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic [31:0]       inst;
  logic              inst_valid;
  logic [31:0]       dout;
  logic              dout_valid;
  logic              stallreq_if;

  modport master (
    output ice, iaddr, dce, daddr,
    output dwe, din, flush, sram_rdata,
    input  sram_en, sram_we, sram_addr,
    input  sram_wdata, inst, inst_valid,
    input  dout, dout_valid, stallreq_if
  );

  modport slave (
    input  ice, iaddr, dce, daddr,
    input  dwe, din, flush, sram_rdata,
    output sram_en, sram_we, sram_addr,
    output sram_wdata, inst, inst_valid,
    output dout, dout_valid, stallreq_if
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port SRAM arbiter: data has priority, fetch is forced
// through after STARVE_LIMIT consecutive data wins.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 32
) (
  input  logic          cpu_clk_50M,
  input  logic          cpu_rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    IRESP,
    DRESP
  } state_t;

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] ADDR_Z = '0;

  state_t     state;
  logic [2:0] starve_cnt;
  logic       forced;
  logic       fetch_gnt;
  logic       data_gnt;
  logic       data_rd;

  always_comb begin
    forced    = bus.ice && (starve_cnt == LIMIT);
    fetch_gnt = !cpu_rst && bus.ice
              && (!bus.dce || forced);
    data_gnt  = !cpu_rst && bus.dce
              && !fetch_gnt;
    data_rd   = data_gnt && (bus.dwe == 4'b0000);
  end

  always_comb begin
    bus.sram_en    = fetch_gnt || data_gnt;
    bus.sram_we    = 4'b0000;
    bus.sram_addr  = ADDR_Z;
    bus.sram_wdata = 32'h0;
    unique case (1'b1)
      fetch_gnt: begin
        bus.sram_addr  = bus.iaddr;
        bus.sram_wdata = bus.din;
      end
      data_gnt: begin
        bus.sram_we    = bus.dwe;
        bus.sram_addr  = bus.daddr;
        bus.sram_wdata = bus.din;
      end
      default: ;
    endcase
  end

  assign bus.stallreq_if = !cpu_rst && bus.ice
                         && !fetch_gnt;

  // Responses follow the state, so reset clears them at once.
  always_comb begin
    bus.inst       = 32'h0;
    bus.inst_valid = 1'b0;
    bus.dout       = 32'h0;
    bus.dout_valid = 1'b0;
    unique case (state)
      IRESP: begin
        bus.inst       = bus.sram_rdata;
        bus.inst_valid = !bus.flush;
      end
      DRESP: begin
        bus.dout       = bus.sram_rdata;
        bus.dout_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      state      <= IDLE;
      starve_cnt <= 3'd0;
    end else begin
      unique case (1'b1)
        fetch_gnt: state <= IRESP;
        data_rd:   state <= DRESP;
        default:   state <= IDLE;
      endcase
      if (fetch_gnt || !bus.ice)
        starve_cnt <= 3'd0;
      else if (data_gnt && starve_cnt != LIMIT)
        starve_cnt <= starve_cnt + 3'd1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle SRAM model.
// Read data pattern: 32'hC0DE0000 | addr[15:0].
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mem_arbiter_if #(.ADDR_W(32)) bus ();

  mem_arbiter #(
    .STARVE_LIMIT(4),
    .ADDR_W(32)
  ) dut (
    .cpu_clk_50M(clk),
    .cpu_rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk)
    if (bus.sram_en && bus.sram_we == 4'b0000)
      bus.sram_rdata <= 32'hC0DE0000
                      | {16'h0, bus.sram_addr[15:0]};

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ice,
                       input logic [31:0] ia,
                       input logic dce,
                       input logic [31:0] da,
                       input logic [3:0] we,
                       input logic [31:0] wd,
                       input logic fl);
    bus.ice   = ice;
    bus.iaddr = ia;
    bus.dce   = dce;
    bus.daddr = da;
    bus.dwe   = we;
    bus.din   = wd;
    bus.flush = fl;
    #5;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.sram_rdata = 32'h0;
    drive(1, 32'h0, 1, 32'h100, 4'h0, 32'h0, 0);
    chk("rst_en", 32'(bus.sram_en), 32'd0);
    chk("rst_stall", 32'(bus.stallreq_if), 32'd0);
    chk("rst_iv", 32'(bus.inst_valid), 32'd0);
    chk("rst_dv", 32'(bus.dout_valid), 32'd0);
    chk("rst_inst", bus.inst, 32'h0);

    // fetch only, first cycle after reset
    step();
    rst = 1'b0;
    drive(1, 32'h0, 0, 32'h0, 4'h0, 32'h0, 0);
    chk("f_en", 32'(bus.sram_en), 32'd1);
    chk("f_addr", bus.sram_addr, 32'h0);
    chk("f_we", 32'(bus.sram_we), 32'd0);
    chk("f_stall", 32'(bus.stallreq_if), 32'd0);
    step();
    drive(0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 0);
    chk("f_iv", 32'(bus.inst_valid), 32'd1);
    chk("f_inst", bus.inst, 32'hC0DE0000);
    chk("f_stall2", 32'(bus.stallreq_if), 32'd0);
    chk("f_en2", 32'(bus.sram_en), 32'd0);

    // collision: data wins, fetch next
    step();
    drive(1, 32'h4, 1, 32'h100, 4'h0, 32'h0, 0);
    chk("c_en", 32'(bus.sram_en), 32'd1);
    chk("c_addr", bus.sram_addr, 32'h100);
    chk("c_stall", 32'(bus.stallreq_if), 32'd1);
    chk("c_iv0", 32'(bus.inst_valid), 32'd0);
    step();
    drive(1, 32'h4, 0, 32'h0, 4'h0, 32'h0, 0);
    chk("c_dv", 32'(bus.dout_valid), 32'd1);
    chk("c_dout", bus.dout, 32'hC0DE0100);
    chk("c_faddr", bus.sram_addr, 32'h4);
    chk("c_stall2", 32'(bus.stallreq_if), 32'd0);
    step();
    drive(0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 0);
    chk("c_inst", bus.inst, 32'hC0DE0004);
    chk("c_dv2", 32'(bus.dout_valid), 32'd0);
    step();
    drive(0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 0);
    chk("idle_iv", 32'(bus.inst_valid), 32'd0);
    chk("idle_inst", bus.inst, 32'h0);

    // starvation: 4 data, forced fetch, data
    for (int i = 1; i <= 6; i++) begin
      step();
      drive(1, 32'h8, 1, 32'h200, 4'h0, 32'h0, 0);
      if (i == 5) begin
        chk("s_faddr", bus.sram_addr, 32'h8);
        chk("s_fstall", 32'(bus.stallreq_if), 32'd0);
      end else begin
        chk($sformatf("s_daddr%0d", i),
            bus.sram_addr, 32'h200);
        chk($sformatf("s_stall%0d", i),
            32'(bus.stallreq_if), 32'd1);
      end
    end
    chk("s_inst", bus.inst, 32'hC0DE0008);
    chk("s_iv", 32'(bus.inst_valid), 32'd1);

    // store
    step();
    drive(0, 32'h0, 1, 32'h300, 4'b0011,
          32'hDEADBEEF, 0);
    chk("w_we", 32'(bus.sram_we), 32'h3);
    chk("w_wd", bus.sram_wdata, 32'hDEADBEEF);
    chk("w_addr", bus.sram_addr, 32'h300);
    chk("w_prev_dout", bus.dout, 32'hC0DE0200);
    step();
    drive(0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 0);
    chk("w_dv", 32'(bus.dout_valid), 32'd0);
    chk("w_we2", 32'(bus.sram_we), 32'd0);
    chk("w_en2", 32'(bus.sram_en), 32'd0);

    // flush in the response cycle squashes
    step();
    drive(1, 32'hC, 0, 32'h0, 4'h0, 32'h0, 0);
    step();
    drive(0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 1);
    chk("fl_sq", 32'(bus.inst_valid), 32'd0);
    // flush in the issue cycle does not
    step();
    drive(1, 32'h10, 0, 32'h0, 4'h0, 32'h0, 1);
    chk("fl_en", 32'(bus.sram_en), 32'd1);
    chk("fl_addr", bus.sram_addr, 32'h10);
    step();
    drive(0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 0);
    chk("fl_iv", 32'(bus.inst_valid), 32'd1);
    chk("fl_inst", bus.inst, 32'hC0DE0010);

    // async reset during a load response
    step();
    drive(0, 32'h0, 1, 32'h40, 4'h0, 32'h0, 0);
    step();
    drive(0, 32'h0, 1, 32'h44, 4'h0, 32'h0, 0);
    chk("ar_dv", 32'(bus.dout_valid), 32'd1);
    chk("ar_en", 32'(bus.sram_en), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_dv0", 32'(bus.dout_valid), 32'd0);
    chk("ar_en0", 32'(bus.sram_en), 32'd0);
    chk("ar_dout0", bus.dout, 32'h0);
    step();
    rst = 1'b0;
    drive(1, 32'h20, 0, 32'h0, 4'h0, 32'h0, 0);
    chk("ar_gnt", 32'(bus.sram_en), 32'd1);
    chk("ar_addr", bus.sram_addr, 32'h20);
    step();
    drive(0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 0);
    chk("ar_inst", bus.inst, 32'hC0DE0020);
    chk("ar_iv", 32'(bus.inst_valid), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
